// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and parameter defaults.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int MC_MAX_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_MC  = 2'd1,
    ST_MEM = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-status inputs and stage-control outputs exchanged between the datapath and pipe_ctrl.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_is_load;
  logic                  ex_redirect;
  logic                  mc_start;
  logic                  mc_done;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  pc_sel_redirect;
  logic                  if_id_valid;
  logic                  if_id_flush;
  logic                  id_ex_valid;
  logic                  id_ex_flush;
  logic                  ex_mem_valid;
  logic                  ex_mem_flush;
  logic                  mem_wb_valid;
  logic                  mc_timeout;

  modport master (
    input  id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_is_load,
           ex_redirect, mc_start, mc_done, mem_req, mem_ready,
    output pc_en, pc_sel_redirect, if_id_valid, if_id_flush, id_ex_valid,
           id_ex_flush, ex_mem_valid, ex_mem_flush, mem_wb_valid, mc_timeout
  );

  modport slave (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_is_load,
           ex_redirect, mc_start, mc_done, mem_req, mem_ready,
    input  pc_en, pc_sel_redirect, if_id_valid, if_id_flush, id_ex_valid,
           id_ex_flush, ex_mem_valid, ex_mem_flush, mem_wb_valid, mc_timeout
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use detector: a load in EX writes a register the ID instruction reads.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  // x0 is never a real destination, so it cannot create a hazard
  assign load_use = ex_is_load & (ex_rd != {REG_ADDR_W{1'b0}}) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage advance/flush and PC control for the 5-stage core.
// Build macro PIPE_CTRL_PERF_EN adds stall/redirect/load-use performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_MAX_CYC = MC_MAX_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.master bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_lu_cnt
`endif
);

  localparam int               CNT_W    = $clog2(MC_MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_r, state_s, ret_r, ret_s, eff_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             pend_r, pend_s, timeout_r, timeout_s;
  logic             load_use_s, stall_s, done_s, mc_act_s, last_s;
  logic             pc_en_s, sel_s, ifv_s, iff_s, idv_s, idf_s, exv_s, exf_s, wbv_s;

  pipe_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .load_use   (load_use_s)
  );

  // MEM_WAIT behaves as its return state once memory is ready
  assign stall_s  = bus.mem_req & ~bus.mem_ready;
  assign eff_s    = (state_r == ST_MEM) ? ret_r : state_r;
  assign done_s   = bus.mc_done | pend_r;
  assign mc_act_s = (eff_s == ST_MC) | ((eff_s == ST_RUN) & bus.mc_start);
  assign last_s   = (eff_s == ST_MC) & (cnt_r == CNT_LAST);

  // Stage controls by priority: reset, memory stall, mul/div, redirect, load-use
  always_comb begin
    pc_en_s = 1'b1; sel_s = 1'b0;
    ifv_s = 1'b1; iff_s = 1'b0; idv_s = 1'b1; idf_s = 1'b0;
    exv_s = 1'b1; exf_s = 1'b0; wbv_s = 1'b1;
    if (reset) begin
      pc_en_s = 1'b0; ifv_s = 1'b0; iff_s = 1'b1; idv_s = 1'b0; idf_s = 1'b1;
      exv_s = 1'b0; exf_s = 1'b1; wbv_s = 1'b0;
    end else if (stall_s) begin
      pc_en_s = 1'b0; ifv_s = 1'b0; idv_s = 1'b0; exv_s = 1'b0; wbv_s = 1'b0;
    end else if (mc_act_s) begin
      pc_en_s = 1'b0; ifv_s = 1'b0; idv_s = 1'b0;
      exv_s = done_s; exf_s = ~done_s;
    end else if (bus.ex_redirect) begin
      sel_s = 1'b1; iff_s = 1'b1; idf_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s = 1'b0; ifv_s = 1'b0; idf_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Next state, return state, occupancy counter and pending-done flag
  always_comb begin
    state_s = state_r; ret_s = ret_r; cnt_s = cnt_r; pend_s = pend_r; timeout_s = 1'b0;
    if (stall_s) begin
      state_s = ST_MEM;
      ret_s   = (eff_s == ST_MC) ? ST_MC : ST_RUN;
      pend_s  = pend_r | ((eff_s == ST_MC) & bus.mc_done);
    end else if (eff_s == ST_MC) begin
      if (done_s | last_s) begin
        state_s = ST_RUN; ret_s = ST_RUN; cnt_s = CNT_ZERO; pend_s = 1'b0;
        timeout_s = ~done_s;
      end else begin
        state_s = ST_MC; ret_s = ST_RUN; cnt_s = cnt_r + CNT_ONE; pend_s = 1'b0;
      end
    end else if (bus.mc_start & ~bus.mc_done) begin
      // the mc_start cycle is the first occupancy cycle
      state_s = ST_MC; ret_s = ST_RUN; cnt_s = CNT_ONE; pend_s = 1'b0;
    end else begin
      state_s = ST_RUN; ret_s = ST_RUN; cnt_s = CNT_ZERO; pend_s = 1'b0;
    end
  end

  // FSM and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN; ret_r <= ST_RUN; cnt_r <= CNT_ZERO;
      pend_r <= 1'b0; timeout_r <= 1'b0;
    end else begin
      state_r <= state_s; ret_r <= ret_s; cnt_r <= cnt_s;
      pend_r <= pend_s; timeout_r <= timeout_s;
    end
  end

  assign bus.pc_en           = pc_en_s;
  assign bus.pc_sel_redirect = sel_s;
  assign bus.if_id_valid     = ifv_s;
  assign bus.if_id_flush     = iff_s;
  assign bus.id_ex_valid     = idv_s;
  assign bus.id_ex_flush     = idf_s;
  assign bus.ex_mem_valid    = exv_s;
  assign bus.ex_mem_flush    = exf_s;
  assign bus.mem_wb_valid    = wbv_s;
  assign bus.mc_timeout      = timeout_r & ~reset;

`ifdef PIPE_CTRL_PERF_EN
  // Event counters; a load-use bubble is the only case with pc_en low and id_ex_flush high
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= 32'd0; perf_flush_cnt <= 32'd0; perf_lu_cnt <= 32'd0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + {31'd0, ~pc_en_s};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, sel_s};
      perf_lu_cnt    <= perf_lu_cnt + {31'd0, ~pc_en_s & idf_s};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with an expected-output scoreboard queue.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  // {pc_en, pc_sel_redirect, if_id_v, if_id_f, id_ex_v, id_ex_f, ex_mem_v, ex_mem_f, mem_wb_v, mc_timeout}
  localparam logic [9:0] E_NORM  = 10'b1010101010;
  localparam logic [9:0] E_RST   = 10'b0001010100;
  localparam logic [9:0] E_STALL = 10'b0000000000;
  localparam logic [9:0] E_REDIR = 10'b1111111010;
  localparam logic [9:0] E_LU    = 10'b0000111010;
  localparam logic [9:0] E_MCB   = 10'b0000000110;
  localparam logic [9:0] E_MCD   = 10'b0000001010;
  localparam logic [9:0] E_TMO   = 10'b1010101011;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];
  logic [9:0] obs;

  pipe_ctrl_if #(.REG_ADDR_W(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

  pipe_ctrl #(.REG_ADDR_W(5), .MC_MAX_CYC(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {bus.pc_en, bus.pc_sel_redirect, bus.if_id_valid, bus.if_id_flush,
                bus.id_ex_valid, bus.id_ex_flush, bus.ex_mem_valid, bus.ex_mem_flush,
                bus.mem_wb_valid, bus.mc_timeout};

  task automatic check_out();
    logic [9:0] e;
    string      t;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
    end
  endtask

  // one cycle: record expectation, sample on the falling edge, advance past the rising edge
  task automatic tick(input logic [9:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.ex_rd = 5'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_redirect = 1'b0; bus.mc_start = 1'b0; bus.mc_done = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    tick(E_RST, "reset_0");
    tick(E_RST, "reset_1");
    reset = 1'b0;
    tick(E_NORM, "run_idle");

    // load-use through rs1: lw x5 ; add x6,x5,x1
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd1;
    tick(E_LU, "lu_rs1");
    bus.ex_is_load = 1'b0;
    tick(E_NORM, "lu_after");
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    tick(E_NORM, "lu_x0");
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7;
    tick(E_LU, "lu_rs2");
    bus.id_use_rs2 = 1'b0;
    tick(E_NORM, "lu_rs2_unused");
    bus.ex_is_load = 1'b0;

    // redirect alone, then together with a load-use match
    bus.ex_redirect = 1'b1;
    tick(E_REDIR, "redirect");
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd9;
    tick(E_REDIR, "redirect_over_lu");
    bus.ex_redirect = 1'b0; bus.ex_is_load = 1'b0;
    tick(E_NORM, "redirect_after");

    // mul/div done after 10 busy cycles
    bus.mc_start = 1'b1;
    tick(E_MCB, "mc_start");
    bus.mc_start = 1'b0;
    for (int i = 1; i < 10; i++) tick(E_MCB, "mc_busy");
    bus.mc_done = 1'b1;
    tick(E_MCD, "mc_done");
    bus.mc_done = 1'b0;
    tick(E_NORM, "mc_after");

    // plain memory wait in RUN
    bus.mem_req = 1'b1;
    tick(E_STALL, "mem_run_stall");
    bus.mem_ready = 1'b1;
    tick(E_NORM, "mem_run_ready");
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

    // memory wait during mul/div with mc_done arriving in the stall
    bus.mc_start = 1'b1;
    tick(E_MCB, "mcm_start");
    bus.mc_start = 1'b0;
    tick(E_MCB, "mcm_busy1");
    tick(E_MCB, "mcm_busy2");
    bus.mem_req = 1'b1;
    tick(E_STALL, "mcm_stall1");
    bus.mc_done = 1'b1;
    tick(E_STALL, "mcm_stall2");
    bus.mc_done = 1'b0;
    tick(E_STALL, "mcm_stall3");
    bus.mem_ready = 1'b1;
    tick(E_MCD, "mcm_ready");
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    tick(E_NORM, "mcm_run");

    // watchdog: no mc_done at all
    bus.mc_start = 1'b1;
    tick(E_MCB, "wd_start");
    bus.mc_start = 1'b0;
    for (int i = 1; i < 64; i++) tick(E_MCB, "wd_busy");
    tick(E_TMO, "wd_timeout");
    tick(E_NORM, "wd_after");

    // reset while in MEM_WAIT
    bus.mc_start = 1'b1;
    tick(E_MCB, "rmw_start");
    bus.mc_start = 1'b0; bus.mem_req = 1'b1;
    tick(E_STALL, "rmw_stall1");
    tick(E_STALL, "rmw_stall2");
    reset = 1'b1;
    tick(E_RST, "rmw_reset0");
`ifdef PIPE_CTRL_PERF_EN
    n_assert++;
    assert ((perf_stall_cyc === 32'd0) && (perf_flush_cnt === 32'd0) && (perf_lu_cnt === 32'd0)) else begin
      n_fail++;
      $error("FAIL perf_clear observed=%0d/%0d/%0d expected=0/0/0", perf_stall_cyc, perf_flush_cnt, perf_lu_cnt);
    end
`endif
    tick(E_RST, "rmw_reset1");
    reset = 1'b0; bus.mem_req = 1'b0;
    tick(E_NORM, "rmw_run");

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
